// File: rtl/fp_uart_sequencer_if.sv
// Handshake bundle between the frame sequencer, the RX FIFO / UART transmitter and the FPU.
// Signal names match the legacy flat port list so existing wiring maps one-to-one.
interface fp_uart_sequencer_if;
   logic        rx_empty;
   logic [7:0]  rx_data;
   logic        rx_rd_en;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_done_tick;
   logic [1:0]  fpu_op;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic        fpu_start;
   logic        fpu_done;
   logic [31:0] fpu_result;

   modport master (
      input  rx_empty, rx_data, tx_done_tick, fpu_done, fpu_result,
      output rx_rd_en, tx_data, tx_start, fpu_op, fpu_a, fpu_b, fpu_start
   );

   modport slave (
      output rx_empty, rx_data, tx_done_tick, fpu_done, fpu_result,
      input  rx_rd_en, tx_data, tx_start, fpu_op, fpu_a, fpu_b, fpu_start
   );
endinterface

// File: rtl/fp_uart_sequencer.sv
// Frame controller: pops opcode + two 32-bit operands from the RX FIFO, runs the FPU,
// and streams the result (or a single error byte) back through the UART transmitter.
module fp_uart_sequencer #(
   parameter logic [15:0] RX_TIMEOUT  = 16'd50000,
   parameter logic [15:0] FPU_TIMEOUT = 16'd1000,
   parameter int unsigned NUM_OPS     = 4
) (
   input  logic                       clk_100MHz,
   input  logic                       reset,
   fp_uart_sequencer_if.master        bus,
   output logic                       busy,
   output logic [1:0]                 err_code,
   output logic [2:0]                 state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_A   = 3'd1,
      GET_B   = 3'd2,
      LAUNCH  = 3'd3,
      RUN     = 3'd4,
      SEND    = 3'd5,
      WAIT_TX = 3'd6,
      ERR_TX  = 3'd7
   } state_t;

   localparam logic [7:0] BYTE_BAD_OP = 8'hEE;
   localparam logic [7:0] BYTE_RX_TO  = 8'hED;
   localparam logic [7:0] BYTE_FPU_TO = 8'hEF;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] tmo_q, tmo_d;
   logic [1:0]  err_q, err_d;
   logic [7:0]  ebyte_q, ebyte_d;

   logic        pop;
   logic        tx_go;
   logic        launch;
   logic [7:0]  tx_byte;
   logic [15:0] tmo_inc;

   assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      ebyte_d = ebyte_q;
      pop     = 1'b0;
      tx_go   = 1'b0;
      launch  = 1'b0;
      tx_byte = '0;

      unique case (state_q)
         IDLE: begin
            if (!bus.rx_empty) begin
               pop = 1'b1;
               if (32'(bus.rx_data) < NUM_OPS) begin
                  op_d    = bus.rx_data[1:0];
                  cnt_d   = '0;
                  tmo_d   = '0;
                  state_d = GET_A;
               end else begin
                  err_d   = 2'd1;
                  ebyte_d = BYTE_BAD_OP;
                  tx_go   = 1'b1;
                  tx_byte = BYTE_BAD_OP;
                  state_d = ERR_TX;
               end
            end
         end

         // An available byte always wins over the inter-byte timeout.
         GET_A, GET_B: begin
            if (!bus.rx_empty) begin
               pop   = 1'b1;
               tmo_d = '0;
               cnt_d = cnt_q + 2'd1;
               if (state_q == GET_A) a_d = {a_q[23:0], bus.rx_data};
               else                  b_d = {b_q[23:0], bus.rx_data};
               if (cnt_q == 2'd3) state_d = (state_q == GET_A) ? GET_B : LAUNCH;
            end else if (tmo_q >= RX_TIMEOUT - 16'd1) begin
               err_d   = 2'd2;
               ebyte_d = BYTE_RX_TO;
               tx_go   = 1'b1;
               tx_byte = BYTE_RX_TO;
               a_d     = '0;
               b_d     = '0;
               state_d = ERR_TX;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         LAUNCH: begin
            launch  = 1'b1;
            tmo_d   = '0;
            state_d = RUN;
         end

         RUN: begin
            if (bus.fpu_done) begin
               res_d   = bus.fpu_result;
               idx_d   = 2'd3;
               err_d   = 2'd0;
               state_d = SEND;
            end else if (tmo_q >= FPU_TIMEOUT - 16'd1) begin
               err_d   = 2'd3;
               ebyte_d = BYTE_FPU_TO;
               tx_go   = 1'b1;
               tx_byte = BYTE_FPU_TO;
               state_d = ERR_TX;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         SEND: begin
            tx_go   = 1'b1;
            tx_byte = res_q[{idx_q, 3'b000} +: 8];
            state_d = WAIT_TX;
         end

         WAIT_TX: begin
            tx_byte = res_q[{idx_q, 3'b000} +: 8];
            if (bus.tx_done_tick) begin
               if (idx_q == 2'd0) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q - 2'd1;
                  state_d = SEND;
               end
            end
         end

         ERR_TX: begin
            tx_byte = ebyte_q;
            if (bus.tx_done_tick) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         tmo_q   <= '0;
         err_q   <= '0;
         ebyte_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         ebyte_q <= ebyte_d;
      end
   end

   // Strobes are masked while reset is held so no pop/launch/write escapes the reset cycle.
   assign bus.rx_rd_en  = pop    & ~reset;
   assign bus.tx_start  = tx_go  & ~reset;
   assign bus.fpu_start = launch & ~reset;
   assign bus.tx_data   = reset ? '0 : tx_byte;
   assign bus.fpu_op    = op_q;
   assign bus.fpu_a     = a_q;
   assign bus.fpu_b     = b_q;
   assign busy          = (state_q != IDLE);
   assign err_code      = err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_fp_uart_sequencer.sv
// Randomized and directed bench for fp_uart_sequencer with FIFO, UART and FPU models
// and a frame-level reference for the expected byte stream and FPU calls.
module tb_fp_uart_sequencer;

   localparam int RX_TO  = 200;
   localparam int FPU_TO = 100;
   localparam int NOPS   = 4;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic [1:0] err_code;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   fp_uart_sequencer_if bus ();

   fp_uart_sequencer #(
      .RX_TIMEOUT (16'(RX_TO)),
      .FPU_TIMEOUT(16'(FPU_TO)),
      .NUM_OPS    (NOPS)
   ) dut (
      .clk_100MHz(clk),
      .reset     (reset),
      .bus       (bus.master),
      .busy      (busy),
      .err_code  (err_code),
      .state_dbg (state_dbg)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0]  rxq[$];
   logic [7:0]  txlog[$];
   logic [7:0]  exp_tx[$];
   int          pop_cyc[$];
   int          txs_cyc[$];
   int          txdone_cyc[$];
   int          fstart_cyc[$];
   int          fdone_cyc[$];
   logic [1:0]  fop[$];
   logic [31:0] fa[$];
   logic [31:0] fb[$];
   logic [1:0]  exp_op[$];
   logic [31:0] exp_a[$];
   logic [31:0] exp_b[$];
   logic [1:0]  exp_err;

   logic rand_gaps     = 1'b0;
   logic fpu_hang      = 1'b0;
   logic late_done_req = 1'b0;
   int   tx_cnt        = 0;
   int   fpu_cnt       = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Stand-in FPU: exact IEEE results for the directed cases, an arbitrary mix otherwise.
   function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      return (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {30'd0, op};
   endfunction

   // Environment: samples DUT strobes mid-cycle, reacts just after the next rising edge.
   initial begin : env
      logic        s_pop, s_txs, s_fs, tx_armed;
      logic [7:0]  s_txd, tx_held;
      logic [31:0] pend_res;
      logic        rx_block;
      tx_armed = 1'b0;
      tx_held  = '0;
      pend_res = '0;
      rx_block = 1'b0;
      bus.rx_empty     = 1'b1;
      bus.rx_data      = '0;
      bus.tx_done_tick = 1'b0;
      bus.fpu_done     = 1'b0;
      bus.fpu_result   = '0;
      forever begin
         @(negedge clk);
         s_pop = bus.rx_rd_en;
         s_txs = bus.tx_start;
         s_fs  = bus.fpu_start;
         s_txd = bus.tx_data;
         if (s_pop) begin
            check_eq("pop_while_empty", 32'(bus.rx_empty), 32'd0);
            pop_cyc.push_back(cyc);
         end
         if (s_txs) begin
            txlog.push_back(s_txd);
            txs_cyc.push_back(cyc);
         end
         if (bus.tx_done_tick && tx_armed) begin
            check_eq("tx_data_hold", 32'(bus.tx_data), 32'(tx_held));
            tx_armed = 1'b0;
         end
         if (s_fs) begin
            fop.push_back(bus.fpu_op);
            fa.push_back(bus.fpu_a);
            fb.push_back(bus.fpu_b);
            fstart_cyc.push_back(cyc);
            pend_res = fpu_fn(bus.fpu_op, bus.fpu_a, bus.fpu_b);
         end

         @(posedge clk);
         #1;
         cyc++;
         bus.tx_done_tick = 1'b0;
         bus.fpu_done     = 1'b0;
         if (reset) begin
            tx_cnt   = 0;
            fpu_cnt  = 0;
            tx_armed = 1'b0;
         end else begin
            if (s_pop && rxq.size() > 0) void'(rxq.pop_front());
            if (tx_cnt > 0) begin
               tx_cnt--;
               if (tx_cnt == 0) begin
                  bus.tx_done_tick = 1'b1;
                  txdone_cyc.push_back(cyc);
               end
            end
            if (s_txs) begin
               tx_cnt   = $urandom_range(2, 6);
               tx_armed = 1'b1;
               tx_held  = s_txd;
            end
            if (fpu_cnt > 0) begin
               fpu_cnt--;
               if (fpu_cnt == 0) begin
                  bus.fpu_done   = 1'b1;
                  bus.fpu_result = pend_res;
                  fdone_cyc.push_back(cyc);
               end
            end
            if (s_fs && !fpu_hang) fpu_cnt = $urandom_range(1, 8);
            if (late_done_req) begin
               bus.fpu_done   = 1'b1;
               bus.fpu_result = 32'hDEADBEEF;
               late_done_req  = 1'b0;
            end
         end
         rx_block    = rand_gaps && ($urandom_range(0, 3) == 0);
         bus.rx_empty = rx_block || (rxq.size() == 0);
         bus.rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
      end
   end

   task automatic clear_logs();
      txlog.delete(); exp_tx.delete(); pop_cyc.delete(); txs_cyc.delete();
      txdone_cyc.delete(); fstart_cyc.delete(); fdone_cyc.delete();
      fop.delete(); fa.delete(); fb.delete();
      exp_op.delete(); exp_a.delete(); exp_b.delete();
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      rxq.push_back(op);
      if (32'(op) < NOPS) begin
         for (int i = 3; i >= 0; i--) rxq.push_back(a[8*i +: 8]);
         for (int i = 3; i >= 0; i--) rxq.push_back(b[8*i +: 8]);
         r = fpu_fn(op[1:0], a, b);
         exp_op.push_back(op[1:0]);
         exp_a.push_back(a);
         exp_b.push_back(b);
         for (int i = 3; i >= 0; i--) exp_tx.push_back(r[8*i +: 8]);
         exp_err = 2'd0;
      end else begin
         exp_tx.push_back(8'hEE);
         exp_err = 2'd1;
      end
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rxq.size() == 0 && !busy && tx_cnt == 0) begin
            done = 1'b1;
            break;
         end
      end
      check_eq("wait_idle_bound", 32'(done), 32'd1);
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, "_tx_count"}, 32'(txlog.size()), 32'(exp_tx.size()));
      foreach (exp_tx[i]) check_eq({tag, "_tx_byte"}, 32'(txlog[i]), 32'(exp_tx[i]));
      check_eq({tag, "_fpu_calls"}, 32'(fa.size()), 32'(exp_a.size()));
      foreach (exp_a[i]) begin
         check_eq({tag, "_fpu_op"}, 32'(fop[i]), 32'(exp_op[i]));
         check_eq({tag, "_fpu_a"}, fa[i], exp_a[i]);
         check_eq({tag, "_fpu_b"}, fb[i], exp_b[i]);
      end
      check_eq({tag, "_err_code"}, 32'(err_code), 32'(exp_err));
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_rd_en"}, 32'(bus.rx_rd_en), 32'd0);
      check_eq({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check_eq({tag, "_fpu_start"}, 32'(bus.fpu_start), 32'd0);
      check_eq({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      check_eq({tag, "_fpu_a"}, bus.fpu_a, 32'd0);
      check_eq({tag, "_fpu_b"}, bus.fpu_b, 32'd0);
      check_eq({tag, "_fpu_op"}, 32'(bus.fpu_op), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_err"}, 32'(err_code), 32'd0);
      check_eq({tag, "_state"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin : stim
      logic [7:0]  op;
      logic [31:0] a, b;
      logic        seen;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;

      // Directed add frame, FIFO never empty.
      clear_logs();
      send_frame(8'h00, 32'h3F800000, 32'h40000000);
      wait_idle(400);
      compare_all("add");
      check_eq("add_pop_count", 32'(pop_cyc.size()), 32'd9);
      check_eq("add_pop_consecutive", 32'(pop_cyc[8] - pop_cyc[0]), 32'd8);
      check_eq("add_launch_latency", 32'(fstart_cyc[0] - pop_cyc[8]), 32'd1);
      check_eq("add_first_tx_latency", 32'(txs_cyc[0] - fdone_cyc[0]), 32'd1);

      // Bad opcode, then a good frame clears the error.
      clear_logs();
      send_frame(8'h07, '0, '0);
      wait_idle(200);
      compare_all("badop");
      clear_logs();
      send_frame(8'h01, 32'h41200000, 32'h3F000000);
      wait_idle(400);
      compare_all("after_badop");

      // RX stall mid-operand A.
      clear_logs();
      rxq.push_back(8'h00); rxq.push_back(8'h12); rxq.push_back(8'h34);
      exp_tx.push_back(8'hED);
      exp_err = 2'd2;
      wait_idle(RX_TO + 100);
      compare_all("rx_timeout");
      check_eq("rx_timeout_when", 32'(txs_cyc[0] - pop_cyc[2]), 32'(RX_TO));

      // FPU never answers; a stray done afterwards must be ignored.
      clear_logs();
      fpu_hang = 1'b1;
      send_frame(8'h02, 32'h40000000, 32'h40400000);
      exp_tx.delete();
      exp_tx.push_back(8'hEF);
      exp_err = 2'd3;
      wait_idle(FPU_TO + 200);
      compare_all("fpu_timeout");
      check_eq("fpu_timeout_when", 32'(txs_cyc[0] - fstart_cyc[0]), 32'(FPU_TO));
      late_done_req = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("late_done_no_tx", 32'(txlog.size()), 32'd1);
      check_eq("late_done_idle", 32'(busy), 32'd0);
      check_eq("late_done_err", 32'(err_code), 32'd3);
      fpu_hang = 1'b0;

      // Randomized frame stream with short RX gaps.
      clear_logs();
      rand_gaps = 1'b1;
      for (int f = 0; f < 25; f++) begin
         if ($urandom_range(0, 9) < 7) op = 8'($urandom_range(0, NOPS - 1));
         else                          op = 8'($urandom_range(NOPS, 255));
         a = $urandom;
         b = $urandom;
         send_frame(op, a, b);
      end
      wait_idle(25 * 200);
      rand_gaps = 1'b0;
      compare_all("random");

      // Back-to-back multiply frames preloaded.
      clear_logs();
      send_frame(8'h02, 32'h40000000, 32'h40400000);
      send_frame(8'h02, 32'h40000000, 32'h40400000);
      wait_idle(800);
      compare_all("b2b");
      check_eq("b2b_no_early_pop", 32'(pop_cyc[9] > txdone_cyc[3]), 32'd1);
      check_eq("b2b_second_result", {txlog[4], txlog[5], txlog[6], txlog[7]}, 32'h40C00000);

      // Reset while waiting for the 2nd result byte to finish.
      clear_logs();
      send_frame(8'h00, 32'h3F800000, 32'h40000000);
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (txlog.size() == 2) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("rst_reach_byte2", 32'(seen), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("midtx_reset");
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("midtx_no_more_tx", 32'(txlog.size()), 32'd2);
      check_eq("midtx_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no completion expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fp_uart_sequencer.md
Name: fp_uart_sequencer

Overview:
- Frame-level controller between the UART/FIFO datapath and the floating-point unit.
- Pops a command frame from the RX FIFO: 1 opcode byte, then operand A (4 bytes), then operand B (4 bytes), all MSB first.
- Issues the operation to the FPU over a start/done handshake, then returns the 32-bit result MSB first through the UART transmitter.
- Reports malformed frames, RX stalls and FPU hangs with a single error byte.

Parameters:
- RX_TIMEOUT, 16'd50000: maximum idle cycles between consecutive bytes inside a frame before the frame is aborted.
- FPU_TIMEOUT, 16'd1000: maximum cycles from fpu_start to fpu_done.
- NUM_OPS, 4: opcodes 0..NUM_OPS-1 are valid (0 add, 1 sub, 2 mul, 3 div).

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_empty  in  1  RX FIFO empty flag
- rx_data  in  8  RX FIFO head byte (first-word-fall-through; valid while !rx_empty)
- rx_rd_en  out  1  one-cycle pop of the RX FIFO head
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle UART write strobe
- tx_done_tick  in  1  UART byte transmitted
- fpu_op  out  2  operation select
- fpu_a  out  32  operand A
- fpu_b  out  32  operand B
- fpu_start  out  1  one-cycle FPU launch
- fpu_done  in  1  one-cycle FPU completion; fpu_result valid this cycle
- fpu_result  in  32  FPU result
- busy  out  1  high in every state except IDLE
- err_code  out  2  last error: 0 none, 1 bad opcode, 2 RX timeout, 3 FPU timeout (sticky until next good frame)
- state_dbg  out  3  current state encoding, for LEDs

Behaviour:
- Clock and reset: one clock, clk_100MHz. Reset is synchronous and active-high and takes priority over every other event. It forces:
  - state IDLE;
  - all outputs 0;
  - internal counters, shift registers and result latch cleared.
- Reset mid-frame or mid-transmit aborts silently: no tx_start, rx_rd_en or fpu_start in the cycle after reset.
- Each pop is: rx_rd_en high for exactly one cycle while !rx_empty; rx_data is captured in that same cycle. rx_rd_en is never asserted while rx_empty=1.
- States and transitions:
  - IDLE: when !rx_empty, pop the opcode.
    - Opcode < NUM_OPS: latch fpu_op, clear the byte count, go to GET_A.
    - Otherwise: err_code=1, tx byte 0xEE, go to ERR_TX.
  - GET_A: pop 4 bytes, shifting fpu_a left by 8 each pop. After the 4th pop go to GET_B.
  - GET_B: same as GET_A for fpu_b. After the 4th pop go to LAUNCH.
  - LAUNCH: fpu_start=1 for one cycle, clear the timeout counter, go to RUN. fpu_a, fpu_b and fpu_op stay stable until RUN exits.
  - RUN: on fpu_done, latch fpu_result, set byte index 3, clear err_code, go to SEND. If the counter reaches FPU_TIMEOUT-1 without fpu_done: err_code=3, tx 0xEF, go to ERR_TX. An fpu_done arriving in the same cycle as the timeout wins.
  - SEND: drive tx_data = result[8*idx+7:8*idx] and pulse tx_start, then go to WAIT_TX.
  - WAIT_TX: on tx_done_tick, if idx=0 go to IDLE, else decrement idx and return to SEND.
  - ERR_TX: pulse tx_start with the error byte, wait for tx_done_tick, go to IDLE.
- RX timeout: the inter-byte counter runs in GET_A/GET_B while rx_empty=1 and clears on every pop. On reaching RX_TIMEOUT-1: err_code=2, tx 0xED, go to ERR_TX. Partial operands are discarded.
- A byte available in the same cycle as the timeout is popped and the timeout does not fire.
- Latency: LAUNCH occurs 1 cycle after the 9th pop. The first tx_start occurs 1 cycle after fpu_done.
- tx_data is held from tx_start until tx_done_tick. tx_done_tick in any state other than WAIT_TX/ERR_TX is ignored.
- fpu_done outside RUN is ignored.
- Bytes arriving during RUN/SEND stay in the FIFO and are not popped until IDLE.
- Counters are 16-bit and saturate, with no wrap.

Test Plan:
- Frame 00 3F800000 40000000 with rx_empty=0 throughout → exactly 9 rx_rd_en pulses on consecutive cycles; fpu_op=0, fpu_a=32'h3F800000, fpu_b=32'h40000000, one fpu_start. Model returns 32'h40400000 → tx bytes 40,40,00,00 in order, one per tx_done_tick, then busy=0.
- Opcode 0x07 → err_code=1, single tx byte 0xEE, return to IDLE; next valid frame completes normally and err_code returns to 0.
- Opcode plus 2 bytes of A, then FIFO empty for RX_TIMEOUT cycles → tx 0xED, err_code=2; no fpu_start ever asserted.
- Valid frame with fpu_done withheld → tx 0xEF at exactly FPU_TIMEOUT cycles after fpu_start; a late fpu_done is ignored.
- Reset asserted during WAIT_TX after the 2nd result byte → next cycle all outputs 0 and state IDLE; no further tx_start.
- Back-to-back frames preloaded in the FIFO (mul 40000000×40400000) → second frame not popped until the 4th tx_done_tick of the first; second result 40C00000.
